vc_shiftregisters_2d_win: RTL and testbench

VC_SHIFTREGISTERS_2D_WIN -- requirements
Module: vc_shiftregisters_2d_win

---
 rtl/vc_shiftregisters_pkg.sv | 13 +
 rtl/vc_shiftregisters_1d_win.sv | 68 ++++++
 rtl/vc_shiftregisters_2d_win.sv | 51 +++++
 tb/tb_vc_shiftregisters_2d_win.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/vc_shiftregisters_pkg.sv
// Shared helpers for the windowed shift-register family:
// counter width and stride legality.
package vc_shiftregisters_pkg;

    function automatic int cw_width(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic bit stride_legal(input int stride, input int width);
        return (stride >= 1) && (stride <= width);
    endfunction

endpackage

// File: rtl/vc_shiftregisters_1d_win.sv
// One row: data chain (slot 0 newest), occupancy
// counter and valid/ready handshake on both sides.
module vc_shiftregisters_1d_win
    import vc_shiftregisters_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int WIDTH      = 8,
    parameter int STRIDE     = 1,
    localparam int CW        = cw_width(WIDTH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DATA_WIDTH-1:0]       i_msg,
    input  logic                        i_val,
    output logic                        o_rdy,
    input  logic                        i_clear,
    output logic [DATA_WIDTH*WIDTH-1:0] o_win_msg,
    output logic [WIDTH-1:0]            o_elem_val,
    output logic                        o_win_val,
    input  logic                        i_win_rdy,
    output logic [CW-1:0]               o_count
);

    localparam logic [CW-1:0] FULL = CW'(WIDTH);
    localparam logic [CW-1:0] STEP = CW'(STRIDE);

    logic [DATA_WIDTH-1:0] r_data [WIDTH];
    logic [CW-1:0]         r_count;
    logic [CW-1:0]         w_count_nxt;
    logic                  w_in_fire;
    logic                  w_win_fire;

    assign o_win_val  = (r_count == FULL);
    // clear masks the consumer so a flush never also retires
    assign w_win_fire = o_win_val & i_win_rdy & ~i_clear;
    assign o_rdy      = ~i_clear & ((r_count < FULL) | w_win_fire);
    assign w_in_fire  = i_val & o_rdy;
    assign o_count    = r_count;

    always_comb begin
        w_count_nxt = r_count;
        if (i_clear) begin
            w_count_nxt = '0;
        end else begin
            if (w_win_fire) w_count_nxt = w_count_nxt - STEP;
            if (w_in_fire)  w_count_nxt = w_count_nxt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            for (int i = 0; i < WIDTH; i++) r_data[i] <= '0;
        end else begin
            r_count <= w_count_nxt;
            if (w_in_fire) begin
                r_data[0] <= i_msg;
                for (int i = 1; i < WIDTH; i++) r_data[i] <= r_data[i-1];
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_slot
        assign o_win_msg[i*DATA_WIDTH +: DATA_WIDTH] = r_data[i];
        assign o_elem_val[i] = (r_count > CW'(i));
    end

endmodule

// File: rtl/vc_shiftregisters_2d_win.sv
// HEIGHT independent sliding-window rows; this level
// is wiring only, each row is a 1d_win instance.
module vc_shiftregisters_2d_win
    import vc_shiftregisters_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int HEIGHT     = 8,
    parameter int WIDTH      = 8,
    parameter int STRIDE     = 1,
    localparam int CW        = cw_width(WIDTH)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [DATA_WIDTH*HEIGHT-1:0]       in_msg,
    input  logic [HEIGHT-1:0]                  in_val,
    output logic [HEIGHT-1:0]                  in_rdy,
    input  logic [HEIGHT-1:0]                  clear,
    output logic [DATA_WIDTH*HEIGHT*WIDTH-1:0] win_msg,
    output logic [HEIGHT*WIDTH-1:0]            elem_val,
    output logic [HEIGHT-1:0]                  win_val,
    input  logic [HEIGHT-1:0]                  win_rdy,
    output logic [HEIGHT*CW-1:0]               count
);

    localparam int RW = DATA_WIDTH * WIDTH;

    if (!stride_legal(STRIDE, WIDTH)) begin : g_bad_stride
        $error("vc_shiftregisters_2d_win: STRIDE must be in 1..WIDTH");
    end

    for (genvar r = 0; r < HEIGHT; r++) begin : g_row
        vc_shiftregisters_1d_win #(
            .DATA_WIDTH (DATA_WIDTH),
            .WIDTH      (WIDTH),
            .STRIDE     (STRIDE)
        ) u_row (
            .clk        (clk),
            .rst_n      (reset),
            .i_msg      (in_msg[r*DATA_WIDTH +: DATA_WIDTH]),
            .i_val      (in_val[r]),
            .o_rdy      (in_rdy[r]),
            .i_clear    (clear[r]),
            .o_win_msg  (win_msg[r*RW +: RW]),
            .o_elem_val (elem_val[r*WIDTH +: WIDTH]),
            .o_win_val  (win_val[r]),
            .i_win_rdy  (win_rdy[r]),
            .o_count    (count[r*CW +: CW])
        );
    end

endmodule

// File: tb/tb_vc_shiftregisters_2d_win.sv
// Table, directed and random checks of the 2d window
// against a queue model; second instance at STRIDE=1.
module tb_vc_shiftregisters_2d_win;

    localparam int DW = 8;
    localparam int H  = 2;
    localparam int W  = 4;
    localparam int S  = 2;
    localparam int CW = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [DW*H-1:0]   in_msg;
    logic [H-1:0]      in_val, in_rdy, clear, win_val, win_rdy;
    logic [DW*H*W-1:0] win_msg;
    logic [H*W-1:0]    elem_val;
    logic [H*CW-1:0]   count;

    logic [DW*H-1:0]   s_in_msg;
    logic [H-1:0]      s_in_val, s_in_rdy, s_clear, s_win_val, s_win_rdy;
    logic [DW*H*W-1:0] s_win_msg;
    logic [H*W-1:0]    s_elem_val;
    logic [H*CW-1:0]   s_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vc_shiftregisters_2d_win #(
        .DATA_WIDTH(DW), .HEIGHT(H), .WIDTH(W), .STRIDE(S)
    ) dut (
        .clk(clk), .reset(reset), .in_msg(in_msg), .in_val(in_val),
        .in_rdy(in_rdy), .clear(clear), .win_msg(win_msg),
        .elem_val(elem_val), .win_val(win_val), .win_rdy(win_rdy),
        .count(count)
    );

    vc_shiftregisters_2d_win #(
        .DATA_WIDTH(DW), .HEIGHT(H), .WIDTH(W), .STRIDE(1)
    ) dut1 (
        .clk(clk), .reset(reset), .in_msg(s_in_msg), .in_val(s_in_val),
        .in_rdy(s_in_rdy), .clear(s_clear), .win_msg(s_win_msg),
        .elem_val(s_elem_val), .win_val(s_win_val), .win_rdy(s_win_rdy),
        .count(s_count)
    );

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       wr;
        logic       cl;
        logic       rdy;
        logic [2:0] cnt;
        logic [7:0] s0;
        logic [3:0] ev;
    } vec_t;

    vec_t       tbl[12];
    logic [7:0] mq[H][$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        in_val = '0; in_msg = '0; win_rdy = '0; clear = '0;
        s_in_val = '0; s_in_msg = '0; s_win_rdy = '0; s_clear = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int r = 0; r < H; r++) mq[r].delete();
    endtask

    task automatic push(input logic [1:0] v, input logic [15:0] m);
        @(negedge clk);
        in_val = v;
        in_msg = m;
        @(posedge clk);
        #1;
        in_val = '0;
    endtask

    initial begin
        int fires;
        logic [31:0] last_win;

        reset = 1'b1;
        idle();
        #2 reset = 1'b0;
        #1;
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_in_rdy", 64'(in_rdy), 64'h3);
        chk("reset_win_msg", 64'(win_msg), 64'd0);
        do_reset();

        tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 3'd1, 8'h11, 4'b0001};
        tbl[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 3'd2, 8'h22, 4'b0011};
        tbl[2]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 3'd3, 8'h33, 4'b0111};
        tbl[3]  = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 3'd4, 8'h44, 4'b1111};
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd4, 8'h44, 4'b1111};
        tbl[5]  = '{1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 3'd4, 8'h44, 4'b1111};
        tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd2, 8'h44, 4'b0011};
        tbl[7]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 3'd3, 8'h55, 4'b0111};
        tbl[8]  = '{1'b1, 8'h66, 1'b0, 1'b0, 1'b1, 3'd4, 8'h66, 4'b1111};
        tbl[9]  = '{1'b1, 8'h77, 1'b1, 1'b0, 1'b1, 3'd3, 8'h77, 4'b0111};
        tbl[10] = '{1'b1, 8'h88, 1'b0, 1'b0, 1'b1, 3'd4, 8'h88, 4'b1111};
        tbl[11] = '{1'b1, 8'hAA, 1'b1, 1'b1, 1'b0, 3'd0, 8'h88, 4'b0000};

        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            in_val  = {1'b0, tbl[k].v};
            in_msg  = {8'h00, tbl[k].d};
            win_rdy = {1'b0, tbl[k].wr};
            clear   = {1'b0, tbl[k].cl};
            #1;
            chk("tbl_in_rdy", 64'(in_rdy[0]), 64'(tbl[k].rdy));
            @(posedge clk);
            #1;
            chk("tbl_count", 64'(count[2:0]), 64'(tbl[k].cnt));
            chk("tbl_slot0", 64'(win_msg[7:0]), 64'(tbl[k].s0));
            chk("tbl_elem_val", 64'(elem_val[3:0]), 64'(tbl[k].ev));
            chk("tbl_row1_count", 64'(count[5:3]), 64'd0);
        end

        do_reset();
        push(2'b01, 16'h0011);
        push(2'b01, 16'h0022);
        push(2'b01, 16'h0033);
        push(2'b01, 16'h0044);
        chk("fill_win_val", 64'(win_val), 64'h1);
        chk("fill_window", 64'(win_msg[31:0]), 64'h11223344);
        chk("fill_in_rdy", 64'(in_rdy[0]), 64'd0);
        chk("fill_row1_count", 64'(count[5:3]), 64'd0);
        @(negedge clk);
        win_rdy = 2'b01;
        @(posedge clk);
        #1;
        win_rdy = 2'b00;
        chk("stride_count", 64'(count[2:0]), 64'd2);
        chk("stride_slots", 64'(win_msg[15:0]), 64'h3344);
        chk("stride_elem_val", 64'(elem_val[3:0]), 64'b0011);

        do_reset();
        push(2'b11, 16'hA166);
        push(2'b01, 16'h0077);
        @(negedge clk);
        #3 reset = 1'b0;
        #1;
        chk("areset_count", 64'(count), 64'd0);
        chk("areset_win_msg", 64'(win_msg), 64'd0);
        chk("areset_elem_val", 64'(elem_val), 64'd0);
        chk("areset_win_val", 64'(win_val), 64'd0);
        chk("areset_in_rdy", 64'(in_rdy), 64'h3);
        @(negedge clk);
        reset = 1'b1;
        push(2'b01, 16'h00C3);
        chk("areset_first_fill", 64'(count[2:0]), 64'd1);
        chk("areset_first_slot", 64'(win_msg[7:0]), 64'hC3);

        do_reset();
        for (int c = 0; c < 400; c++) begin
            logic [1:0] exp_rdy;
            @(negedge clk);
            in_val  = 2'($urandom);
            in_msg  = 16'($urandom);
            win_rdy = 2'($urandom);
            clear   = {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)};
            #1;
            for (int r = 0; r < H; r++) begin
                int sz;
                sz = mq[r].size();
                exp_rdy[r] = !clear[r] && (sz < W || win_rdy[r]);
                chk("rnd_in_rdy", 64'(in_rdy[r]), 64'(exp_rdy[r]));
                chk("rnd_win_val", 64'(win_val[r]), 64'(sz == W));
                chk("rnd_count", 64'(count[r*CW +: CW]), 64'(sz));
                chk("rnd_elem_val", 64'(elem_val[r*W +: W]), (64'd1 << sz) - 64'd1);
                for (int i = 0; i < sz; i++)
                    chk("rnd_slot", 64'(win_msg[(r*W+i)*DW +: DW]), 64'(mq[r][i]));
            end
            @(posedge clk);
            #1;
            for (int r = 0; r < H; r++) begin
                if (clear[r]) begin
                    mq[r].delete();
                end else begin
                    if (mq[r].size() == W && win_rdy[r])
                        repeat (S) void'(mq[r].pop_back());
                    if (in_val[r] && exp_rdy[r])
                        mq[r].push_front(in_msg[r*DW +: DW]);
                end
            end
        end

        do_reset();
        fires = 0;
        last_win = '0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            s_in_val  = (c < 8) ? 2'b01 : 2'b00;
            s_in_msg  = {8'h00, 8'(c + 1)};
            s_win_rdy = 2'b01;
            #1;
            if (s_win_val[0]) begin
                fires++;
                last_win = s_win_msg[31:0];
            end
        end
        chk("slide_fires", 64'(fires), 64'd5);
        chk("slide_last_window", 64'(last_win), 64'h05060708);

        idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
